// File: rtl/grid_phase_ctrl_pkg.sv
// Shared definitions for the grid phase controller: phase encoding and parameter defaults.
// Optional build macro used by the top: GRID_PHASE_FRAME_CNT_EN.
package grid_phase_ctrl_pkg;

  localparam int unsigned NUM_PARTICLES_DEF = 16384;
  localparam int unsigned NUM_ADDRS_DEF     = 1024;
  localparam int unsigned SOLVE_LAT_DEF     = 8;
  localparam int unsigned PHASE_W           = 3;
  localparam int unsigned FRAME_CNT_W       = 16;

  typedef enum logic [PHASE_W-1:0] {
    IDLE    = 3'd0,
    SCATTER = 3'd1,
    DRAIN   = 3'd2,
    SOLVE   = 3'd3,
    FLUSH   = 3'd4
  } phase_t;

endpackage

// File: rtl/grid_phase_ctrl_valid_delay.sv
// Fixed-depth shift register carrying a payload (valid bit included) with synchronous clear.
module valid_delay #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/grid_phase_ctrl.sv
// Frame sequencer for the particle scatter / charge solve pipeline.
// Define GRID_PHASE_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is 0.
module grid_phase_ctrl
  import grid_phase_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PARTICLES = NUM_PARTICLES_DEF,
  parameter int unsigned NUM_ADDRS     = NUM_ADDRS_DEF,
  parameter int unsigned SOLVE_LAT     = SOLVE_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         part_valid,
  output logic                         part_ready,
  output logic                         scat_valid,
  input  logic                         scat_done,
  input  logic                         solve_ready,
  output logic                         req_valid,
  output logic [$clog2(NUM_ADDRS)-1:0] req_idx_a,
  output logic [$clog2(NUM_ADDRS)-1:0] req_idx_b,
  output logic                         chg_valid,
  output logic [$clog2(NUM_ADDRS)-1:0] chg_idx,
  output logic [PHASE_W-1:0]           phase,
  output logic                         frame_done,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int unsigned AW = $clog2(NUM_ADDRS);
  localparam int unsigned PW = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1;
  localparam int unsigned FW = (SOLVE_LAT > 1) ? $clog2(SOLVE_LAT + 1) : 1;
  localparam int unsigned DW = AW + 1;

  phase_t        state_q, state_d;
  logic [PW-1:0] part_cnt_q, part_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          issue_c;
  logic          frame_done_d;
  logic [DW-1:0] dly_out;

  assign scat_valid = part_valid & part_ready;
  assign phase      = state_q;

  // Next-state and counter updates; abort overrides everything and kills the pending pulse.
  always_comb begin
    state_d      = state_q;
    part_cnt_d   = part_cnt_q;
    addr_d       = addr_q;
    flush_cnt_d  = flush_cnt_q;
    issue_c      = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCATTER;
          part_cnt_d = '0;
          addr_d     = '0;
        end
      end
      SCATTER: begin
        if (scat_valid) begin
          part_cnt_d = part_cnt_q + PW'(1);
          if (part_cnt_q == PW'(NUM_PARTICLES - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (scat_done) state_d = SOLVE;
      end
      SOLVE: begin
        if (solve_ready) begin
          issue_c = 1'b1;
          addr_d  = addr_q + AW'(2);
          if (addr_q == AW'(NUM_ADDRS - 2)) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FW'(SOLVE_LAT - 1)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d      = IDLE;
      issue_c      = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      part_cnt_q  <= '0;
      addr_q      <= '0;
      flush_cnt_q <= '0;
      part_ready  <= 1'b0;
      req_valid   <= 1'b0;
      req_idx_a   <= '0;
      req_idx_b   <= '0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      part_cnt_q  <= part_cnt_d;
      addr_q      <= addr_d;
      flush_cnt_q <= flush_cnt_d;
      part_ready  <= (state_d == SCATTER);
      req_valid   <= issue_c;
      frame_done  <= frame_done_d;
      if (issue_c) begin
        req_idx_a <= addr_q;
        req_idx_b <= addr_q + AW'(1);
      end
    end
  end

  // Request pair index travels alongside its valid so chg_idx names the returning data.
  valid_delay #(
    .DEPTH (SOLVE_LAT),
    .WIDTH (DW)
  ) u_chg_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .din   ({req_valid, req_idx_a}),
    .dout  (dly_out)
  );

  assign chg_valid = dly_out[AW];
  assign chg_idx   = dly_out[AW-1:0];

`ifdef GRID_PHASE_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_done_d) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
